seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux -- time-multiplexed 7-segment display scanner.
//
// A prescaler divides clk into digit slots of REFRESH_DIV cycles. Each slot
// lights one digit (one-hot SEG_SEL) with its hex-decoded segments plus the
// decimal point (SEG_DATA). The digit/dp/blank inputs are captured into
// snapshot registers at the end of every frame, so a frame never mixes old
// and new values. While en is low the display is dark and the snapshots
// follow the inputs continuously. When scanning restarts, the first slot
// therefore shows the values present on the last disabled cycle.
//
// Build option: define SEG_SCAN_LZB_EN to enable leading-zero blanking. A
// digit other than digit 0 then shows no segments when it and every
// more-significant snapshot digit are zero. Its decimal point still follows
// dp. Digit 0 always shows its value. With the macro undefined, every digit
// decodes normally.
//
// Output map: SEG_DATA[7] = dp, SEG_DATA[6:0] = segments g..a, all active-high.

module seg_scan_mux #(
  parameter int NUM_DIGITS  = 5,      // 1..8 multiplexed digits
  parameter int REFRESH_DIV = 50000   // clk cycles per digit slot, >= 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   SEG_SEL,
  output logic [7:0]              SEG_DATA,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             tick;   // last cycle of the current slot
  logic             wrap;   // last cycle of the last slot of the frame

  // Frame-stable copies of the inputs
  logic [4*NUM_DIGITS-1:0] snap_digits_reg;
  logic [NUM_DIGITS-1:0]   snap_dp_reg;
  logic [NUM_DIGITS-1:0]   snap_blank_reg;

  // Per-slot output values and the values for the active slot
  logic [7:0]            slot_data [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sel_next;
  logic [7:0]            data_next;

  // Hex digit to segments g..a (bit 0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;   // 4'hF
    endcase
    return s;
  endfunction

  assign tick = en && (cnt_reg == CNT_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);

  // Prescaler and digit index; both park at zero while disabled so a
  // re-enable starts a full-length slot on digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (!en) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
      if (tick) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end
    end
  end

  // Snapshot capture: at each frame boundary, and continuously while dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digits_reg <= '0;
      snap_dp_reg     <= '0;
      snap_blank_reg  <= '0;
    end else if (!en || wrap) begin
      snap_digits_reg <= digits;
      snap_dp_reg     <= dp;
      snap_blank_reg  <= blank;
    end
  end

  // Per-slot segment pattern from the snapshot, plus the one-hot select.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      logic [3:0] digit_val;
      logic       lz_blank;
      logic [6:0] seg_val;

      assign digit_val = snap_digits_reg[4*gi +: 4];

`ifdef SEG_SCAN_LZB_EN
      if (gi > 0) begin : g_lzb
        // This digit and everything above it are zero.
        assign lz_blank = (snap_digits_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end else begin : g_units
        assign lz_blank = 1'b0;
      end
`else
      assign lz_blank = 1'b0;
`endif

      assign seg_val        = lz_blank ? 7'h00 : hex_to_seg(digit_val);
      assign slot_data[gi]  = snap_blank_reg[gi] ? 8'h00 : {snap_dp_reg[gi], seg_val};
      assign sel_next[gi]   = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // AND-OR mux of the active slot's pattern.
  always_comb begin
    data_next = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_next[i]) begin
        data_next = data_next | slot_data[i];
      end
    end
  end

  // Registered display outputs and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SEG_SEL    <= '0;
      SEG_DATA   <= 8'h00;
      frame_done <= 1'b0;
    end else if (!en) begin
      SEG_SEL    <= '0;
      SEG_DATA   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      SEG_SEL    <= sel_next;
      SEG_DATA   <= data_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux -- directed, table-driven bench for seg_scan_mux.
// A 4-digit, 3-cycle-slot instance covers the scan, decode, dp, blank and
// enable behaviour. A 1-digit, 1-cycle-slot instance covers the
// asynchronous reset and the every-cycle wrap.
// Expected values follow the SEG_SCAN_LZB_EN build option when it is defined.

module tb_seg_scan_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        rst, en;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_done;

  // 1-digit instance
  logic        rst1, en1;
  logic [3:0]  digits1;
  logic [0:0]  dp1, blank1;
  logic [0:0]  seg_sel1;
  logic [7:0]  seg_data1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .SEG_SEL(seg_sel), .SEG_DATA(seg_data), .frame_done(frame_done)
  );

  seg_scan_mux #(.NUM_DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .digits(digits1), .dp(dp1), .blank(blank1),
    .SEG_SEL(seg_sel1), .SEG_DATA(seg_data1), .frame_done(frame_done1)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] exp;     // {slot3, slot2, slot1, slot0} SEG_DATA
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Check n consecutive cycles of a frame starting at cycle k0 (0..11).
  task automatic check_cycles(input logic [31:0] exp, input int k0, input int n, input string tag);
    logic [3:0] es;
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge clk);
      es = 4'(1 << (k / 3));
      chk($sformatf("%s c%0d sel", tag, k), 32'(seg_sel), 32'(es));
      chk($sformatf("%s c%0d data", tag, k), 32'(seg_data), 32'(exp[8*(k/3) +: 8]));
      chk($sformatf("%s c%0d frame_done", tag, k), 32'(frame_done), 32'(k == 11));
    end
  endtask

  // Advance to the next fresh frame_done pulse (new frame starts after it).
  task automatic sync_frame(input string tag);
    int n;
    if (frame_done) @(negedge clk);
    n = 0;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done timeout got 0 expected 1", tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 4'h0, 4'h0, 32'h065B4F66};
    vecs[1] = '{16'hABCD, 4'h0, 4'h0, 32'h777C395E};
    vecs[2] = '{16'h1234, 4'h2, 4'h8, 32'h005BCF66};
    vecs[4] = '{16'h89EF, 4'hF, 4'h0, 32'hFFEFF9F1};
    vecs[5] = '{16'h5670, 4'h1, 4'h1, 32'h6D7D0700};
`ifdef SEG_SCAN_LZB_EN
    vecs[3] = '{16'h0050, 4'h0, 4'h0, 32'h00006D3F};
    vecs[6] = '{16'h0000, 4'hF, 4'h0, 32'h808080BF};
    vecs[7] = '{16'h0300, 4'h0, 4'h0, 32'h004F3F3F};
`else
    vecs[3] = '{16'h0050, 4'h0, 4'h0, 32'h3F3F6D3F};
    vecs[6] = '{16'h0000, 4'hF, 4'h0, 32'hBFBFBFBF};
    vecs[7] = '{16'h0300, 4'h0, 4'h0, 32'h3F4F3F3F};
`endif

    rst = 1'b0; en = 1'b1; digits = 16'h1234; dp = '0; blank = '0;
    rst1 = 1'b0; en1 = 1'b1; digits1 = 4'h7; dp1 = '0; blank1 = '0;
    #1 rst = 1'b1; rst1 = 1'b1;
    #1;
    chk("reset sel", 32'(seg_sel), 32'h0);
    chk("reset data", 32'(seg_data), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("reset held sel", 32'(seg_sel), 32'h0);
    rst = 1'b0; rst1 = 1'b0;

    // First frame after reset shows the zero snapshot everywhere.
    check_cycles(32'h3F3F3F3F, 0, 12, "first frame");
    $display("first frame after reset checked");

    for (int v = 0; v < 8; v++) begin
      digits = vecs[v].digits; dp = vecs[v].dp; blank = vecs[v].blank;
      sync_frame($sformatf("vec%0d", v));
      check_cycles(vecs[v].exp, 0, 12, $sformatf("vec%0d", v));
      $display("vec %0d digits=%h dp=%b blank=%b checked", v,
               vecs[v].digits, vecs[v].dp, vecs[v].blank);
    end

    // Mid-frame input change is held off until the following frame.
    digits = 16'h1234; dp = '0; blank = '0;
    sync_frame("midframe");
    check_cycles(32'h065B4F66, 0, 12, "midframe pre");
    check_cycles(32'h065B4F66, 0, 5, "midframe old");
    digits = 16'hABCD;
    check_cycles(32'h065B4F66, 5, 7, "midframe hold");
    check_cycles(32'h777C395E, 0, 12, "midframe new");
    $display("mid-frame change to abcd checked");

    // Drop en mid-slot, change inputs while dark, re-enable.
    check_cycles(32'h777C395E, 0, 4, "endrop pre");
    en = 1'b0;
    digits = 16'h1234;
    @(negedge clk);
    chk("endrop sel", 32'(seg_sel), 32'h0);
    chk("endrop data", 32'(seg_data), 32'h0);
    chk("endrop frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("endrop dark sel", 32'(seg_sel), 32'h0);
    en = 1'b1;
    check_cycles(32'h065B4F66, 0, 12, "reenable");
    $display("enable drop and restart checked");

    // 1-digit instance: async reset between edges, then wrap every cycle.
    @(negedge clk);
    chk("n1 run sel", 32'(seg_sel1), 32'h1);
    chk("n1 run data", 32'(seg_data1), 32'h07);
    chk("n1 run frame_done", 32'(frame_done1), 32'h1);
    @(posedge clk);
    #2 rst1 = 1'b1;
    #1;
    chk("n1 async sel", 32'(seg_sel1), 32'h0);
    chk("n1 async data", 32'(seg_data1), 32'h0);
    chk("n1 async frame_done", 32'(frame_done1), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("n1 held frame_done", 32'(frame_done1), 32'h0);
    rst1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("n1 c%0d sel", k), 32'(seg_sel1), 32'h1);
      chk($sformatf("n1 c%0d data", k), 32'(seg_data1), (k == 0) ? 32'h3F : 32'h07);
      chk($sformatf("n1 c%0d frame_done", k), 32'(frame_done1), 32'h1);
    end
    $display("single-digit async reset and wrap checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
